// File: rtl/wide_add_seq_pkg.sv
// Shared definitions for the wide add/subtract sequencer:
// FSM state encoding and the fixed 32-bit slice width.
package wide_add_seq_pkg;

  localparam int WIDTH = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/wide_add_seq_adder.sv
// Combinational 32-bit adder slice with carry in/out.
// Ports: a_i, b_i, cin_i in; sum_o, cout_o out.
module wide_add_seq_adder
  import wide_add_seq_pkg::*;
(
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  assign {cout_o, sum_o} = {1'b0, a_i}
                         + {1'b0, b_i}
                         + {{WIDTH{1'b0}}, cin_i};

endmodule

// File: rtl/wide_add_seq.sv
// WORDS*32-bit add/sub sequencer reusing one 32-bit slice,
// LSW first. Ports: clk_i, rst_n_i, start_i, a_i, b_i, cin_i,
// sub_i (only with WIDE_ADD_SUB_EN), ready_o, done_o, sum_o,
// cout_o. Define WIDE_ADD_SUB_EN to enable subtraction.
module wide_add_seq
  import wide_add_seq_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   start_i,
  input  logic [WORDS*WIDTH-1:0] a_i,
  input  logic [WORDS*WIDTH-1:0] b_i,
  input  logic                   cin_i,
`ifdef WIDE_ADD_SUB_EN
  input  logic                   sub_i,
`endif
  output logic                   ready_o,
  output logic                   done_o,
  output logic [WORDS*WIDTH-1:0] sum_o,
  output logic                   cout_o
);

  localparam int W  = WORDS * WIDTH;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  state_e          state_q;
  logic [IW-1:0]   idx_q;
  logic            carry_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    sum_q;
  logic            cout_q;
  logic            done_q;
  logic            ready_q;

  logic [W-1:0]     b_d;
  logic             carry_d;
  logic [WIDTH-1:0] s_sum;
  logic             s_cout;

  always_comb begin
    b_d     = b_i;
    carry_d = cin_i;
`ifdef WIDE_ADD_SUB_EN
    if (sub_i) begin
      b_d     = ~b_i;
      carry_d = 1'b1;
    end
`endif
  end

  // Operands shift right each RUN cycle so the
  // current word is always in the low slice.
  wide_add_seq_adder u_slice (
    .a_i    (a_q[WIDTH-1:0]),
    .b_i    (b_q[WIDTH-1:0]),
    .cin_i  (carry_q),
    .sum_o  (s_sum),
    .cout_o (s_cout)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            state_q <= S_RUN;
            a_q     <= a_i;
            b_q     <= b_d;
            carry_q <= carry_d;
            idx_q   <= '0;
            ready_q <= 1'b0;
          end else begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
          end
        end
        S_RUN: begin
          a_q     <= a_q >> WIDTH;
          b_q     <= b_q >> WIDTH;
          carry_q <= s_cout;
          idx_q   <= idx_q + IW'(1);
          for (int w = 0; w < WORDS; w++) begin
            if (idx_q == IW'(w)) begin
              sum_q[w*WIDTH +: WIDTH] <= s_sum;
            end
          end
          if (idx_q == LAST) begin
            cout_q  <= s_cout;
            done_q  <= 1'b1;
            ready_q <= 1'b1;
            idx_q   <= '0;
            state_q <= S_DONE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready_o = ready_q;
  assign done_o  = done_q;
  assign sum_o   = sum_q;
  assign cout_o  = cout_q;

endmodule

// File: tb/tb_wide_add_seq.sv
// Self-checking bench for wide_add_seq (WORDS=4):
// directed cases plus random ops against an arithmetic model.
module tb_wide_add_seq;

`ifdef WIDE_ADD_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic         clk_i = 1'b0;
  logic         rst_n_i;
  logic         start_i;
  logic [127:0] a_i;
  logic [127:0] b_i;
  logic         cin_i;
  logic         sub_i;
  logic         ready_o;
  logic         done_o;
  logic [127:0] sum_o;
  logic         cout_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  wide_add_seq #(.WORDS(4)) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .start_i (start_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .cin_i   (cin_i),
`ifdef WIDE_ADD_SUB_EN
    .sub_i   (sub_i),
`endif
    .ready_o (ready_o),
    .done_o  (done_o),
    .sum_o   (sum_o),
    .cout_o  (cout_o)
  );

  task automatic chk(input string tag,
                     input logic [128:0] obs,
                     input logic [128:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [128:0] model(
      input logic [127:0] a, input logic [127:0] b,
      input logic c, input logic s);
    logic [128:0] r;
    if (SUB_EN && s)
      r = {1'b0, a} + {1'b0, ~b} + 129'd1;
    else
      r = {1'b0, a} + {1'b0, b} + {128'd0, c};
    return r;
  endfunction

  // Leaves the bench at the negedge of the done cycle.
  task automatic run_op(input string tag,
                        input logic [127:0] a,
                        input logic [127:0] b,
                        input logic c, input logic s,
                        input bit from_done,
                        input bit poke);
    int lat;
    bit ready_low;
    logic [128:0] exp;
    exp = model(a, b, c, s);
    if (!from_done) @(negedge clk_i);
    a_i = a; b_i = b; cin_i = c; sub_i = s;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    a_i = ~a; b_i = ~b; cin_i = ~c;
    lat = 1;
    ready_low = 1'b1;
    while (!done_o && lat < 20) begin
      if (ready_o) ready_low = 1'b0;
      if (poke && lat == 2) begin
        a_i = 128'd5; b_i = 128'd5; start_i = 1'b1;
      end else begin
        start_i = 1'b0;
      end
      @(negedge clk_i);
      lat++;
    end
    start_i = 1'b0;
    chk({tag, "_done"}, {128'd0, done_o}, 129'd1);
    chk({tag, "_lat"}, 129'(lat), 129'd5);
    chk({tag, "_rdy_run"}, {128'd0, ready_low}, 129'd1);
    chk({tag, "_rdy_done"}, {128'd0, ready_o}, 129'd1);
    chk({tag, "_res"}, {cout_o, sum_o}, exp);
  endtask

  task automatic after_pulse(input string tag,
                             input logic [128:0] exp);
    @(negedge clk_i);
    chk({tag, "_pulse"}, {128'd0, done_o}, 129'd0);
    chk({tag, "_hold"}, {cout_o, sum_o}, exp);
  endtask

  initial begin
    logic [127:0] ra, rb;
    logic rc, rs;
    rst_n_i = 1'b0; start_i = 1'b0;
    a_i = '0; b_i = '0; cin_i = 1'b0; sub_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("rst_ready", {128'd0, ready_o}, 129'd1);
    chk("rst_done", {128'd0, done_o}, 129'd0);
    chk("rst_res", {cout_o, sum_o}, 129'd0);
    rst_n_i = 1'b1;
    @(negedge clk_i);

    run_op("t1", {128{1'b1}}, 128'd1, 1'b0, 1'b0, 0, 0);
    chk("t1_exact", {cout_o, sum_o}, {1'b1, 128'd0});
    after_pulse("t1", {1'b1, 128'd0});

    run_op("t2", 128'h1_FFFFFFFF, 128'd1, 1'b1, 1'b0, 0, 0);
    chk("t2_exact", {cout_o, sum_o}, {1'b0, 128'h2_00000001});

    run_op("t3", 128'h1234_5678_9ABC_DEF0_0F0F_F0F0_AAAA_5555,
           128'hFFFF_0000_1111_2222_3333_4444_5555_6666,
           1'b0, 1'b0, 0, 1);
    after_pulse("t3", model(
      128'h1234_5678_9ABC_DEF0_0F0F_F0F0_AAAA_5555,
      128'hFFFF_0000_1111_2222_3333_4444_5555_6666, 1'b0, 1'b0));
    chk("t3_idle_rdy", {128'd0, ready_o}, 129'd1);

    // Reset mid-RUN while word 2 is in flight.
    @(negedge clk_i);
    a_i = {128{1'b1}}; b_i = {128{1'b1}}; cin_i = 1'b1;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b0;
    #1;
    chk("t4_rst_res", {cout_o, sum_o}, 129'd0);
    chk("t4_rst_done", {128'd0, done_o}, 129'd0);
    chk("t4_rst_rdy", {128'd0, ready_o}, 129'd1);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    run_op("t4", 128'd3, 128'd4, 1'b0, 1'b0, 0, 0);
    chk("t4_exact", {cout_o, sum_o}, 129'd7);

    run_op("t5a", 128'hDEAD_BEEF, 128'hFFFF_FFFF_FFFF_FFFF,
           1'b1, 1'b0, 0, 0);
    run_op("t5b", {4{32'h8000_0001}}, {4{32'h8000_0000}},
           1'b0, 1'b0, 1, 0);
    after_pulse("t5b", model({4{32'h8000_0001}},
                             {4{32'h8000_0000}}, 1'b0, 1'b0));

    if (SUB_EN) begin
      run_op("t6a", 128'd0, 128'd1, 1'b0, 1'b1, 0, 0);
      chk("t6a_exact", {cout_o, sum_o}, {1'b0, {128{1'b1}}});
      run_op("t6b", 128'd5, 128'd3, 1'b0, 1'b1, 0, 0);
      chk("t6b_exact", {cout_o, sum_o}, {1'b1, 128'd2});
    end

    for (int i = 0; i < 10; i++) begin
      ra = {$urandom, $urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom, $urandom};
      rc = 1'($urandom);
      rs = 1'($urandom);
      run_op($sformatf("rnd%0d", i), ra, rb, rc, rs,
             (i % 3) == 2, 0);
    end
    after_pulse("rnd_last", {cout_o, sum_o});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
